// File: rtl/peripheral_bus_timer.sv
// 32-bit down-counting peripheral-bus timer with busy/ready read handshake and level IRQ.
// Optional prescaler register at 0x10 enabled by defining TIMER_PRESCALER_EN.
module peripheral_bus_timer #(
  parameter logic [15:0] DEVICE_ADDRESS = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        peripheralBus_we,
  input  logic        peripheralBus_oe,
  output logic        peripheralBus_busy,
  input  logic [23:0] peripheralBus_address,
  input  logic [3:0]  peripheralBus_byteSelect,
  input  logic [31:0] peripheralBus_dataWrite,
  output logic [31:0] peripheralBus_dataRead,
  output logic        timer_irq
);

  typedef enum logic [5:0] {
    REG_CONFIG   = 6'h00,
    REG_RELOAD   = 6'h01,
    REG_VALUE    = 6'h02,
    REG_STATUS   = 6'h03,
    REG_PRESCALE = 6'h04
  } reg_sel_e;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  logic        enable_q, enable_d;
  logic        periodic_q, periodic_d;
  logic        irq_en_q, irq_en_d;
  logic [31:0] reload_q, reload_d;
  logic [31:0] value_q, value_d;
  logic        expired_q, expired_d;
  logic        write_done_q, write_done_d;
  logic        read_ready_q, read_ready_d;
  logic [31:0] read_buffer_q, read_buffer_d;
  logic        irq_q, irq_d;

  logic        selected;
  logic        write_commit;
  logic        read_start;
  logic [5:0]  word_idx;
  logic        wr_config, wr_reload, wr_value, wr_status;
  logic        tick;
  logic [31:0] rd_data;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^peripheralBus_address[1:0];
  assign word_idx     = peripheralBus_address[7:2];
  assign selected     = (peripheralBus_address[23:8] == DEVICE_ADDRESS) &&
                        (peripheralBus_we || peripheralBus_oe);
  assign write_commit = selected && peripheralBus_we && !write_done_q;
  assign read_start   = selected && peripheralBus_oe && !read_ready_q;

  assign wr_config = write_commit && (word_idx == REG_CONFIG);
  assign wr_reload = write_commit && (word_idx == REG_RELOAD);
  assign wr_value  = write_commit && (word_idx == REG_VALUE);
  assign wr_status = write_commit && (word_idx == REG_STATUS);

`ifdef TIMER_PRESCALER_EN
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] pcount_q, pcount_d;
  logic        wr_prescale;
  logic [31:0] prescale_merged;

  assign wr_prescale     = write_commit && (word_idx == REG_PRESCALE);
  assign tick            = enable_q && (pcount_q == prescale_q);
  assign prescale_merged = lane_merge({16'h0000, prescale_q}, peripheralBus_dataWrite,
                                      {2'b00, peripheralBus_byteSelect[1:0]});

  always_comb begin
    prescale_d = prescale_q;
    if (wr_prescale) prescale_d = prescale_merged[15:0];
    pcount_d = pcount_q + 16'd1;
    if (!enable_q || wr_value || (pcount_q == prescale_q)) pcount_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q <= '0;
      pcount_q   <= '0;
    end else begin
      prescale_q <= prescale_d;
      pcount_q   <= pcount_d;
    end
  end
`else
  assign tick = enable_q;
`endif

  always_comb begin
    rd_data = '0;
    case (word_idx)
      REG_CONFIG:   rd_data = {29'd0, irq_en_q, periodic_q, enable_q};
      REG_RELOAD:   rd_data = reload_q;
      REG_VALUE:    rd_data = value_q;
      REG_STATUS:   rd_data = {31'd0, expired_q};
`ifdef TIMER_PRESCALER_EN
      REG_PRESCALE: rd_data = {16'd0, prescale_q};
`endif
      default:      rd_data = '0;
    endcase
  end

  // Ordering encodes priority: count first, then bus writes override, except
  // that an expiry set is applied after a STATUS clear so the set wins.
  always_comb begin
    enable_d   = enable_q;
    periodic_d = periodic_q;
    irq_en_d   = irq_en_q;
    reload_d   = reload_q;
    value_d    = value_q;
    expired_d  = expired_q;

    if (wr_status && peripheralBus_byteSelect[0] && peripheralBus_dataWrite[0])
      expired_d = 1'b0;

    if (tick) begin
      if (value_q != '0) begin
        value_d = value_q - 32'd1;
      end else begin
        expired_d = 1'b1;
        if (periodic_q) value_d  = reload_q;
        else            enable_d = 1'b0;
      end
    end

    if (wr_config && peripheralBus_byteSelect[0]) begin
      enable_d   = peripheralBus_dataWrite[0];
      periodic_d = peripheralBus_dataWrite[1];
      irq_en_d   = peripheralBus_dataWrite[2];
    end
    if (wr_reload) reload_d = lane_merge(reload_q, peripheralBus_dataWrite, peripheralBus_byteSelect);
    if (wr_value)  value_d  = lane_merge(value_q, peripheralBus_dataWrite, peripheralBus_byteSelect);
  end

  always_comb begin
    write_done_d  = peripheralBus_we && (write_done_q || write_commit);
    read_ready_d  = selected && peripheralBus_oe;
    read_buffer_d = read_start ? rd_data : read_buffer_q;
    irq_d         = expired_q && irq_en_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q      <= 1'b0;
      periodic_q    <= 1'b0;
      irq_en_q      <= 1'b0;
      reload_q      <= '0;
      value_q       <= '0;
      expired_q     <= 1'b0;
      write_done_q  <= 1'b0;
      read_ready_q  <= 1'b0;
      read_buffer_q <= '0;
      irq_q         <= 1'b0;
    end else begin
      enable_q      <= enable_d;
      periodic_q    <= periodic_d;
      irq_en_q      <= irq_en_d;
      reload_q      <= reload_d;
      value_q       <= value_d;
      expired_q     <= expired_d;
      write_done_q  <= write_done_d;
      read_ready_q  <= read_ready_d;
      read_buffer_q <= read_buffer_d;
      irq_q         <= irq_d;
    end
  end

  // Gated by rst_n so a reset during an access drops busy at once.
  assign peripheralBus_busy     = rst_n && read_start;
  assign peripheralBus_dataRead = (rst_n && selected && peripheralBus_oe && read_ready_q)
                                  ? read_buffer_q : '0;
  assign timer_irq              = irq_q;

endmodule

// File: doc/peripheral_bus_timer.md
# peripheral_bus_timer

32-bit down-counting timer that sits on the peripheral bus directly downstream of the Wishbone-to-peripheral-bus bridge. It decodes its own address window, services bus reads and writes with the bridge's busy/ready handshake, and raises a level interrupt when the count expires. Multiple instances share the bus by OR-ing their read data and busy outputs.

## Interface
Parameters:
- `DEVICE_ADDRESS`, default 16'h0000: value that `peripheralBus_address[23:8]` must match for this instance to respond.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `peripheralBus_we`  in  1  write strobe from the bridge.
- `peripheralBus_oe`  in  1  read strobe from the bridge.
- `peripheralBus_busy`  out  1  stall request to the bridge.
- `peripheralBus_address`  in  24  byte address. `[7:0]` is the register offset.
- `peripheralBus_byteSelect`  in  4  byte lane enables.
- `peripheralBus_dataWrite`  in  32  write data.
- `peripheralBus_dataRead`  out  32  read data. Driven 0 when not selected.
- `timer_irq`  out  1  level interrupt.

## Operation
- Selected when `address[23:8] == DEVICE_ADDRESS` and (`we` or `oe`). Offsets must be word-aligned; `address[1:0]` is ignored.
- Register map:
  - 0x00 CONFIG, reset 0, writable bits [2:0], other bits read 0.
    - bit0 `enable`.
    - bit1 `periodic`.
    - bit2 `irqEnable`.
  - 0x04 RELOAD, reset 0, read/write.
  - 0x08 VALUE, reset 0. Reads return the live count; writes load the counter.
  - 0x0C STATUS. bit0 `expired`. Writing 1 to bit0 clears it; other bits read 0.
  - Unmapped offsets read 0 and ignore writes.
- Writes: each byte lane is written only when its `byteSelect` bit is set. A write commits exactly once per access, on the first cycle of `we`. A `writeDone` flag blocks repeat commits while `we` stays high, and clears when `we` drops.
- Counting, when `enable`=1 (and a tick occurs, see Configuration):
  - VALUE != 0: VALUE decrements by 1.
  - VALUE == 0: `expired` is set.
    - If `periodic`=1, VALUE is loaded from RELOAD.
    - If `periodic`=0, `enable` is cleared and VALUE stays 0.
- Simultaneous events:
  - A bus write to VALUE in the same cycle as a decrement or reload: the write wins.
  - A STATUS clear in the same cycle as an expiry: the set wins.
  - A CONFIG write in the same cycle as a one-shot auto-clear: the write wins.
- `timer_irq = expired & irqEnable`.

## Timing
- Reset values: all registers 0, `writeDone`=0, `readReady`=0.
  - Outputs at reset: `busy`=0, `dataRead`=0, `timer_irq`=0.
- Read handshake, two cycles:
  - Cycle N (selected, `oe`=1, `readReady`=0): `busy`=1 combinationally. The addressed register is captured into `readBuffer`, and `readReady` is set.
  - Cycle N+1: `busy`=0 and `dataRead`=`readBuffer`. The bridge samples the data here.
  - `readReady` clears when `oe` drops or the device is deselected.
- Writes: `busy` stays 0; the write is complete in one cycle.
- The count value captured on a read is the pre-edge value at cycle N.
- `timer_irq` rises one cycle after the expiring edge, since it is derived from registered state.
- When `rst_n` is asserted mid-access, everything clears immediately and `busy` drops.

## Configuration
- `TIMER_PRESCALER_EN` defined:
  - Adds register 0x10 PRESCALE: 16 bits, reset 0, byte-selectable.
  - A 16-bit prescale counter generates one tick every PRESCALE+1 clocks while `enable`=1.
  - The prescale counter is reset to 0 whenever `enable`=0 or VALUE is written.
- `TIMER_PRESCALER_EN` not defined:
  - A tick occurs on every clock.
  - Offset 0x10 is unmapped: reads return 0 and writes are ignored.

## Test plan
- Reset: hold `rst_n`=0 mid-read. Expect `busy`=0, `dataRead`=0, `timer_irq`=0, and every register reading 0 after release.
- Read handshake: write RELOAD=0x12345678, then read 0x04. Expect `busy`=1 for exactly one cycle, then `dataRead`=0x12345678 with `busy`=0.
- Byte lanes: RELOAD=0xFFFFFFFF, then write 0x000000AA with `byteSelect`=4'b0001. Expect RELOAD=0xFFFFFFAA.
- One-shot: VALUE=3, CONFIG=0x5. Expect:
  - `expired`=1 four ticks later.
  - `timer_irq`=1 one cycle after that.
  - `enable` reads 0.
  - Writing STATUS=1 drops `timer_irq`.
- Periodic: RELOAD=2, VALUE=0, CONFIG=0x3. Expect VALUE sequence 0,2,1,0,2… and `expired` set at each 0. A STATUS clear issued in the same cycle as an expiry leaves `expired`=1.
- Decode: `DEVICE_ADDRESS`=16'h0001. A read of address 0x000204 gives `busy`=0 and `dataRead`=0. A read of 0x000104 responds normally.
